// File: rtl/early_div.sv
// early_div: multi-cycle 32-bit integer divider for DIV (signed) / DIVU.
// The leading-zero count of |dividend| pre-normalises the dividend so the
// restoring loop runs only 32-lz iterations.
// Ports:
//   clock, reset       - single clock, synchronous active-high reset
//   start              - request a division (accepted in IDLE or DONE)
//   is_signed          - 1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor  - operands, sampled on the start edge
//   flush              - abort the current operation, return to IDLE
//   busy               - high in PREP, ITER and FIX
//   done               - high for the single DONE cycle
//   quo, rem           - quotient (LO) and remainder (HI), held between results

// Clz: combinational leading-zero count, 32 for an all-zero input.
module Clz (
  input  logic [31:0] value,
  output logic [5:0]  count
);
  always_comb begin
    count = 6'd32;
    // Ascending scan: the highest set bit is the last to write.
    for (int unsigned i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end
endmodule

module early_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state, next_state;
  logic        sgn, sa, sb;
  logic [31:0] mag_a, mag_b, raw_a;
  logic [31:0] a, q;
  logic [31:0] r;
  logic [5:0]  cnt;
  logic [5:0]  lz;
  logic [32:0] r_sh;
  logic        ge;
  logic        start_ok;

  Clz u_clz (
    .value (mag_a),
    .count (lz)
  );

  assign start_ok = start && !flush && (state == IDLE || state == DONE);

  // The partial remainder after each compare/subtract is always below
  // |divisor|, so it is held in 32 bits; only the shifted value needs 33.
  assign r_sh = {r, a[31]};
  assign ge   = r_sh >= {1'b0, mag_b};

  assign busy = (state == PREP) || (state == ITER) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = PREP;
      PREP: begin
        if (mag_b == '0)      next_state = DONE;
        else if (lz == 6'd32) next_state = FIX;
        else                  next_state = ITER;
      end
      ITER: if (cnt == 6'd1) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = start ? PREP : IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sgn   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      raw_a <= '0;
      a     <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      if (start_ok) begin
        sgn   <= is_signed;
        sa    <= is_signed & dividend[31];
        sb    <= is_signed & divisor[31];
        mag_a <= (is_signed && dividend[31]) ? -dividend : dividend;
        mag_b <= (is_signed && divisor[31])  ? -divisor  : divisor;
        raw_a <= dividend;
      end
      case (state)
        PREP: begin
          if (mag_b == '0) begin
            if (!flush) begin
              quo <= '1;
              rem <= raw_a;
            end
          end else begin
            a   <= (lz == 6'd32) ? '0 : (mag_a << lz);
            r   <= '0;
            q   <= '0;
            cnt <= 6'd32 - lz;
          end
        end
        ITER: begin
          r   <= ge ? 32'(r_sh - {1'b0, mag_b}) : r_sh[31:0];
          a   <= a << 1;
          q   <= {q[30:0], ge};
          cnt <= cnt - 6'd1;
        end
        FIX: begin
          if (!flush) begin
            if (sgn) begin
              quo <= (sa ^ sb) ? -q : q;
              rem <= sa ? -r : r;
            end else begin
              quo <= q;
              rem <= r;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_early_div.sv
// tb_early_div: self-checking bench for early_div. Directed cases cover the
// documented corner cases; random operands are compared against an
// arithmetic reference model (native / and %, signed via 64-bit math).
module tb_early_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;

  int total = 0;
  int bad   = 0;

  early_div dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .quo       (quo),
    .rem       (rem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: quotient/remainder from plain arithmetic, latency from the
  // number of significant bits of |dividend|.
  function automatic void model(input bit s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eq, output logic [31:0] er,
                                output int lat);
    longint      dx, dy, qq, rr;
    logic [31:0] m;
    int          n;
    if (y == 0) begin
      eq  = 32'hFFFF_FFFF;
      er  = x;
      lat = 2;
      return;
    end
    if (s) begin
      dx = longint'($signed(x));
      dy = longint'($signed(y));
      qq = dx / dy;
      rr = dx - qq * dy;
      eq = qq[31:0];
      er = rr[31:0];
    end else begin
      eq = x / y;
      er = x % y;
    end
    m = (s && x[31]) ? 32'(0 - x) : x;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    lat = n + 3;
  endfunction

  // Called in cycle 1 of an operation; returns in the DONE cycle.
  task automatic wait_done(input string tag, input int exp_cyc,
                           input logic [31:0] eq, input logic [31:0] er);
    int cyc;
    int busy_err;
    cyc      = 1;
    busy_err = 0;
    while (!done && cyc < 60) begin
      if (!busy) busy_err++;
      tick();
      cyc++;
    end
    check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " quo"}, quo, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " busy_in_op"}, 32'(busy_err), 32'd0);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic launch(input bit s, input logic [31:0] x, input logic [31:0] y);
    is_signed = s;
    dividend  = x;
    divisor   = y;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_div(input string tag, input bit s, input logic [31:0] x,
                         input logic [31:0] y);
    logic [31:0] eq, er;
    int          lat;
    model(s, x, y, eq, er, lat);
    launch(s, x, y);
    wait_done(tag, lat, eq, er);
  endtask

  task automatic idle_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) seen++;
      tick();
    end
    check({tag, " no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] eq, er, x, y;
    int          lat;
    bit          s;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    is_signed = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quo", quo, 32'd0);
    check("reset rem", rem, 32'd0);
    reset = 1'b0;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
    check("divu 100/7 quo const", quo, 32'd14);
    check("divu 100/7 rem const", rem, 32'd2);
    tick();
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 quo const", quo, 32'hFFFF_FFFD);
    check("div -7/2 rem const", rem, 32'hFFFF_FFFF);
    tick();
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div min/-1 quo const", quo, 32'h8000_0000);
    tick();
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    tick();
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0);
    tick();
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    tick();
    run_div("divu 0/5", 1'b0, 32'd0, 32'd5);
    tick();

    // Flush mid-operation keeps the previous result.
    run_div("pre-flush 100/7", 1'b0, 32'd100, 32'd7);
    tick();
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);      // now in cycle 1
    tick(); tick(); tick(); tick();          // cycle 5
    flush = 1'b1;
    tick();                                  // cycle 6
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush quo held", quo, 32'd14);
    check("flush rem held", rem, 32'd2);
    idle_no_done("flush", 40);

    // Start and flush together: start is dropped.
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", {31'd0, busy}, 32'd0);
    idle_no_done("start+flush", 10);
    check("start+flush quo held", quo, 32'd14);

    // Start while busy is ignored.
    model(1'b0, 32'd100, 32'd7, eq, er, lat);
    launch(1'b0, 32'd100, 32'd7);
    tick();
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start while busy", lat - 2, eq, er);
    tick();

    // Back-to-back: restart in the DONE cycle.
    run_div("b2b first", 1'b0, 32'd100, 32'd7);
    is_signed = 1'b0; dividend = 32'd9; divisor = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b done low", {31'd0, done}, 32'd0);
    check("b2b busy high", {31'd0, busy}, 32'd1);
    wait_done("b2b 9/4", 7, 32'd2, 32'd1);
    tick();

    // Reset mid-ITER clears results.
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset quo", quo, 32'd0);
    check("midreset rem", rem, 32'd0);
    tick();

    // Random operands, biased toward short dividends and small divisors.
    for (int k = 0; k < 60; k++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom >> $urandom_range(0, 32);
      y = $urandom >> $urandom_range(0, 32);
      if ($urandom_range(0, 3) == 0) x = -x;
      if ($urandom_range(0, 3) == 0) y = -y;
      if ($urandom_range(0, 9) == 0) y = 32'd0;
      run_div($sformatf("rand%0d s=%0d %08h/%08h", k, s, x, y), s, x, y);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
